// File: rtl/pfxsum_stream_if.sv
// Beat-level handshake bundle for the streaming prefix-sum engine.
// The master side drives input beats and output-side ready; the slave side is the engine.
interface pfxsum_stream_if #(
   parameter int INT_WIDTH = 32,
   parameter int V_LEN     = 8
);
   logic                       valid_in;
   logic                       ready_in;
   logic [INT_WIDTH*V_LEN-1:0] ivec;
   logic                       excl_in;
   logic                       last_in;
   logic                       valid_out;
   logic                       ready_out;
   logic [INT_WIDTH*V_LEN-1:0] ovec;
   logic                       last_out;
   logic                       ovf_out;

   modport master (
      output valid_in, ivec, excl_in, last_in, ready_out,
      input  ready_in, valid_out, ovec, last_out, ovf_out
   );

   modport slave (
      input  valid_in, ivec, excl_in, last_in, ready_out,
      output ready_in, valid_out, ovec, last_out, ovf_out
   );
endinterface

// File: rtl/pfxsum_stream.sv
// Pipelined Kogge-Stone prefix sum over V_LEN lanes per beat, with a running carry
// and sticky overflow chained across the beats of a packet.
module pfxsum_stream #(
   parameter int INT_WIDTH = 32,
   parameter int V_LEN     = 8,
   parameter int LOG_V     = $clog2(V_LEN)
) (
   input logic            clk,
   input logic            rst_n,
   pfxsum_stream_if.slave bus
);
   localparam int SUM_W  = INT_WIDTH + LOG_V;
   localparam int FULL_W = SUM_W + 1;

   logic en;
   assign en          = !bus.valid_out || bus.ready_out;
   assign bus.ready_in = en;

   for (genvar gi = 0; gi < LOG_V; gi++) begin : g_stage
      logic [SUM_W-1:0] cur       [V_LEN];
      logic [SUM_W-1:0] lane_next [V_LEN];
      logic [SUM_W-1:0] lane_reg  [V_LEN];
      logic             vld_src, excl_src, last_src;
      logic             vld_reg, excl_reg, last_reg;

      if (gi == 0) begin : g_src
         assign vld_src  = bus.valid_in;
         assign excl_src = bus.excl_in;
         assign last_src = bus.last_in;
         for (genvar gj = 0; gj < V_LEN; gj++) begin : g_lane
            assign cur[gj] = SUM_W'(bus.ivec[gj*INT_WIDTH +: INT_WIDTH]);
         end
      end else begin : g_src
         assign vld_src  = g_stage[gi-1].vld_reg;
         assign excl_src = g_stage[gi-1].excl_reg;
         assign last_src = g_stage[gi-1].last_reg;
         for (genvar gj = 0; gj < V_LEN; gj++) begin : g_lane
            assign cur[gj] = g_stage[gi-1].lane_reg[gj];
         end
      end

      // Lane i picks up lane i-2^gi; lanes below the stride pass through.
      for (genvar gj = 0; gj < V_LEN; gj++) begin : g_add
         if (gj >= (1 << gi)) begin : g_sum
            assign lane_next[gj] = cur[gj] + cur[gj-(1<<gi)];
         end else begin : g_pass
            assign lane_next[gj] = cur[gj];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_reg  <= 1'b0;
            excl_reg <= 1'b0;
            last_reg <= 1'b0;
            for (int j = 0; j < V_LEN; j++) lane_reg[j] <= '0;
         end else if (en) begin
            vld_reg  <= vld_src;
            excl_reg <= excl_src;
            last_reg <= last_src;
            for (int j = 0; j < V_LEN; j++) lane_reg[j] <= lane_next[j];
         end
      end
   end

   logic [SUM_W-1:0]     fin [V_LEN];
   logic                 fin_vld, fin_excl, fin_last;
   logic [INT_WIDTH-1:0] ovec_next [V_LEN];
   logic [INT_WIDTH-1:0] carry_reg;
   logic                 ovf_sticky_reg;
   logic [FULL_W-1:0]    total_full;
   logic                 bo;

   assign fin_vld  = g_stage[LOG_V-1].vld_reg;
   assign fin_excl = g_stage[LOG_V-1].excl_reg;
   assign fin_last = g_stage[LOG_V-1].last_reg;

   for (genvar gj = 0; gj < V_LEN; gj++) begin : g_out
      assign fin[gj] = g_stage[LOG_V-1].lane_reg[gj];
      if (gj == 0) begin : g_first
         assign ovec_next[gj] = fin_excl ? carry_reg : carry_reg + fin[gj][INT_WIDTH-1:0];
      end else begin : g_rest
         assign ovec_next[gj] = carry_reg +
                                (fin_excl ? fin[gj-1][INT_WIDTH-1:0] : fin[gj][INT_WIDTH-1:0]);
      end
   end

   // Overflow is judged on the inclusive beat total at full precision.
   assign total_full = FULL_W'(carry_reg) + FULL_W'(fin[V_LEN-1]);
   assign bo         = |total_full[FULL_W-1:INT_WIDTH];

   logic                       valid_out_reg;
   logic [INT_WIDTH*V_LEN-1:0] ovec_reg;
   logic                       last_out_reg;
   logic                       ovf_out_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out_reg  <= 1'b0;
         ovec_reg       <= '0;
         last_out_reg   <= 1'b0;
         ovf_out_reg    <= 1'b0;
         carry_reg      <= '0;
         ovf_sticky_reg <= 1'b0;
      end else if (en) begin
         valid_out_reg <= fin_vld;
         if (fin_vld) begin
            for (int j = 0; j < V_LEN; j++) ovec_reg[j*INT_WIDTH +: INT_WIDTH] <= ovec_next[j];
            last_out_reg   <= fin_last;
            ovf_out_reg    <= ovf_sticky_reg | bo;
            carry_reg      <= fin_last ? '0 : total_full[INT_WIDTH-1:0];
            ovf_sticky_reg <= fin_last ? 1'b0 : (ovf_sticky_reg | bo);
         end
      end
   end

   assign bus.valid_out = valid_out_reg;
   assign bus.ovec      = ovec_reg;
   assign bus.last_out  = last_out_reg;
   assign bus.ovf_out   = ovf_out_reg;
endmodule
